stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Control FSM and BCD time counter for the stopwatch; sequences the `clock` divider through its `state` input.
- Consumes the divider's 1 Hz and 2 Hz square waves plus the board buttons and switches.
- Produces the four BCD digits (MM:SS) for the 7-segment mux and a blink enable for adjust mode.
- Sits between the board I/O and the `clock`/display blocks in the top level.

Parameters:
- DEB_CYCLES, 4, consecutive stable clk cycles required before a debounced button level changes (board build overrides, e.g. 500000).
- STATE_BITS, 1, MSB index of the state bus; the bus is STATE_BITS+1 bits wide.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- btnR  input  1  raw pause/resume button, asynchronous.
- btnL  input  1  raw clear button, asynchronous.
- sw  input  2  sw[0]=1 selects adjust mode; sw[1] selects the adjust field (1 = minutes, 0 = seconds).
- oneHz  input  1  1 Hz square wave from `clock`, synchronous to clk.
- twoHz  input  1  2 Hz square wave from `clock`, synchronous to clk.
- state  output  STATE_BITS+1  current FSM state, fed to `clock.state`.
- num0  output  4  seconds ones digit, BCD.
- num1  output  4  seconds tens digit, BCD.
- num2  output  4  minutes ones digit, BCD.
- num3  output  4  minutes tens digit, BCD.
- blink  output  1  adjust-mode blink enable.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE(0); num0..num3=0; blink=0; all sync, debounce and edge registers=0.
- All outputs are registered.
- Button conditioning:
  - Each button passes through a 2-flop synchronizer.
  - A debounce counter updates the debounced level only after the synced value differs from it for DEB_CYCLES consecutive cycles; any bounce restarts the count.
  - A one-cycle press pulse is generated on the rising edge of the debounced level.
  - Latency from raw edge to pulse: 2+DEB_CYCLES cycles (±1).
- Ticks:
  - tick1 = one-cycle pulse on a rising edge of oneHz (previous value registered).
  - tick2 = one-cycle pulse on a rising edge of twoHz.
- State encoding: IDLE=0, RUN=1, PAUSE=2, ADJUST=3. The state output equals the encoding.
- Transitions, evaluated each cycle in priority order:
  1. btnL press: digits cleared to 00:00; next state = ADJUST if sw[0]=1, else IDLE.
  2. sw[0]=1 while not in ADJUST: next state = ADJUST.
  3. ADJUST with sw[0]=0: next state = PAUSE.
  4. btnR press: IDLE→RUN, RUN→PAUSE, PAUSE→RUN; ignored in ADJUST.
- Counting (RUN and tick1):
  - MM:SS BCD increment.
  - num0 9→0 carries into num1; num1 5→0 carries into num2; num2 9→0 carries into num3; num3 5→0.
  - 59:59 wraps to 00:00.
- Adjust (ADJUST and tick2):
  - Increment the selected field by 1 mod 60 (field 59→00), with no carry into the other field.
  - Toggle blink on each tick2.
  - blink is forced to 0 on the cycle the FSM leaves ADJUST and stays 0 outside ADJUST.
- Counts and adjustments use the current-cycle state. Consequences:
  - btnR press coinciding with tick1 in RUN: the increment happens and state goes to PAUSE.
  - btnL press coinciding with tick1: the clear wins; digits = 00:00.
  - sw[1] change mid-adjust takes effect at the next tick2.
- Mid-operation reset assertion returns everything to the reset values immediately; counting resumes only after a fresh btnR press.
- Digits never leave legal BCD ranges: num0/num2 in 0-9, num1/num3 in 0-5.

Test Plan:
- Reset, then idle 10 oneHz periods with no buttons → state=0, digits 00:00, blink=0.
- btnR press, then 5 oneHz rising edges → state=1; num1..num0 = 05; btnR again → state=2; 3 more edges → still 00:05.
- Preload by running to 00:59, 1 tick → 01:00; run to 59:59, 1 tick → 00:00, state stays 1.
- sw=01 in PAUSE at 00:58 → state=3; 3 twoHz edges → 00:01 (seconds wrap, minutes unchanged) and blink toggles 3 times. sw=11 → minutes increment. sw[0]=0 → state=2, blink=0.
- btnR with 2-cycle glitches shorter than DEB_CYCLES → no state change. btnL pressed on the same cycle as tick1 in RUN → digits 00:00, state=0.
- reset pulsed low for 1 cycle mid-RUN at 12:34 → outputs zero asynchronously; after release, state=0 until the next btnR press.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button conditioning, IDLE/RUN/PAUSE/ADJUST sequencing and
// an MM:SS BCD counter with a blink enable for the adjust display.
module stopwatch_ctrl #(
   parameter int DEB_CYCLES = 4,
   parameter int STATE_BITS = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                btnR,
   input  logic                btnL,
   input  logic [1:0]          sw,
   input  logic                oneHz,
   input  logic                twoHz,
   output logic [STATE_BITS:0] state,
   output logic [3:0]          num0,
   output logic [3:0]          num1,
   output logic [3:0]          num2,
   output logic [3:0]          num3,
   output logic                blink
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_PAUSE  = 2'd2,
      S_ADJUST = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   // Index 0 is btnR (pause/resume), index 1 is btnL (clear).
   logic [1:0]      w_raw;
   logic [1:0]      r_sync1;
   logic [1:0]      r_sync2;
   logic [1:0]      r_deb;
   logic [1:0]      r_deb_d;
   logic [CW-1:0]   r_cnt [2];
   logic [1:0]      w_press;
   logic            w_press_r;
   logic            w_press_l;

   logic            r_one_d;
   logic            r_two_d;
   logic            w_tick1;
   logic            w_tick2;

   logic [8:0]      w_sec_inc;
   logic [8:0]      w_min_inc;

   // Returns {carry, tens, ones} for a 00..59 BCD field incremented by one.
   function automatic logic [8:0] bcd60_inc(input logic [3:0] tens, input logic [3:0] ones);
      logic [8:0] res;
      res = {1'b0, tens, ones + 4'd1};
      if (ones == 4'd9) begin
         if (tens == 4'd5) res = 9'h100;
         else              res = {1'b0, tens + 4'd1, 4'd0};
      end
      return res;
   endfunction

   assign w_raw = {btnL, btnR};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_deb   <= '0;
         r_deb_d <= '0;
         r_cnt[0] <= '0;
         r_cnt[1] <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         r_deb_d <= r_deb;
         for (int i = 0; i < 2; i++) begin
            // Any cycle where the synced level agrees with the debounced one restarts the count.
            if (r_sync2[i] == r_deb[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_LAST) begin
               r_deb[i] <= r_sync2[i];
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CW'(1);
            end
         end
      end
   end

   assign w_press   = r_deb & ~r_deb_d;
   assign w_press_r = w_press[0];
   assign w_press_l = w_press[1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_one_d <= 1'b0;
         r_two_d <= 1'b0;
      end else begin
         r_one_d <= oneHz;
         r_two_d <= twoHz;
      end
   end

   assign w_tick1 = oneHz & ~r_one_d;
   assign w_tick2 = twoHz & ~r_two_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_press_l) begin
         w_state_nxt = sw[0] ? S_ADJUST : S_IDLE;
      end else if (sw[0] && (r_state != S_ADJUST)) begin
         w_state_nxt = S_ADJUST;
      end else if ((r_state == S_ADJUST) && !sw[0]) begin
         w_state_nxt = S_PAUSE;
      end else if (w_press_r) begin
         case (r_state)
            S_IDLE:  w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = S_PAUSE;
            S_PAUSE: w_state_nxt = S_RUN;
            default: w_state_nxt = r_state;
         endcase
      end
   end

   assign w_sec_inc = bcd60_inc(num1, num0);
   assign w_min_inc = bcd60_inc(num3, num2);

   // Counting and adjusting look at the current state, so a coinciding press still lets the tick land.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         num0 <= 4'd0;
         num1 <= 4'd0;
         num2 <= 4'd0;
         num3 <= 4'd0;
      end else if (w_press_l) begin
         num0 <= 4'd0;
         num1 <= 4'd0;
         num2 <= 4'd0;
         num3 <= 4'd0;
      end else if ((r_state == S_RUN) && w_tick1) begin
         {num1, num0} <= w_sec_inc[7:0];
         if (w_sec_inc[8]) {num3, num2} <= w_min_inc[7:0];
      end else if ((r_state == S_ADJUST) && w_tick2) begin
         if (sw[1]) {num3, num2} <= w_min_inc[7:0];
         else       {num1, num0} <= w_sec_inc[7:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         blink <= 1'b0;
      end else if (w_state_nxt != S_ADJUST) begin
         blink <= 1'b0;
      end else if ((r_state == S_ADJUST) && w_tick2) begin
         blink <= ~blink;
      end
   end

   assign state = (STATE_BITS + 1)'(r_state);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: hand-computed BCD times, states and blink.
module tb_stopwatch_ctrl;

   localparam int DEB = 4;

   logic       clk;
   logic       reset;
   logic       btnR;
   logic       btnL;
   logic [1:0] sw;
   logic       oneHz;
   logic       twoHz;
   logic [1:0] state;
   logic [3:0] num0, num1, num2, num3;
   logic       blink;

   int n_checks = 0;
   int n_errors = 0;

   stopwatch_ctrl #(.DEB_CYCLES(DEB), .STATE_BITS(1)) dut (
      .clk   (clk),
      .reset (reset),
      .btnR  (btnR),
      .btnL  (btnL),
      .sw    (sw),
      .oneHz (oneHz),
      .twoHz (twoHz),
      .state (state),
      .num0  (num0),
      .num1  (num1),
      .num2  (num2),
      .num3  (num3),
      .blink (blink)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] digits();
      return {num3, num2, num1, num0};
   endfunction

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic one_edge();
      @(negedge clk) oneHz = 1'b1;
      repeat (2) @(negedge clk);
      oneHz = 1'b0;
      repeat (1) @(negedge clk);
   endtask

   task automatic two_edge();
      @(negedge clk) twoHz = 1'b1;
      repeat (2) @(negedge clk);
      twoHz = 1'b0;
      repeat (1) @(negedge clk);
   endtask

   task automatic one_edges(input int n);
      for (int i = 0; i < n; i++) one_edge();
   endtask

   // which: 0 = btnR, 1 = btnL. With with_tick the oneHz edge lands on the press-pulse cycle.
   task automatic press(input int which, input bit with_tick);
      @(negedge clk);
      if (which == 0) btnR = 1'b1;
      else            btnL = 1'b1;
      repeat (2 + DEB) @(negedge clk);
      if (with_tick) oneHz = 1'b1;
      repeat (4) @(negedge clk);
      btnR  = 1'b0;
      btnL  = 1'b0;
      oneHz = 1'b0;
      repeat (DEB + 6) @(negedge clk);
   endtask

   initial begin
      reset = 1'b0;
      btnR  = 1'b0;
      btnL  = 1'b0;
      sw    = 2'b00;
      oneHz = 1'b0;
      twoHz = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_state",  {14'd0, state}, 16'd0);
      check("rst_digits", digits(),       16'h0000);
      check("rst_blink",  {15'd0, blink}, 16'd0);
      reset = 1'b1;

      one_edges(10);
      check("idle_state",  {14'd0, state}, 16'd0);
      check("idle_digits", digits(),       16'h0000);
      check("idle_blink",  {15'd0, blink}, 16'd0);

      press(0, 1'b0);
      check("run_state", {14'd0, state}, 16'd1);
      one_edges(5);
      check("run_5s", digits(), 16'h0005);
      press(0, 1'b0);
      check("pause_state", {14'd0, state}, 16'd2);
      one_edges(3);
      check("pause_hold", digits(), 16'h0005);

      press(0, 1'b0);
      one_edges(54);
      check("run_0059", digits(), 16'h0059);
      one_edge();
      check("carry_0100", digits(), 16'h0100);
      one_edges(3539);
      check("run_5959", digits(), 16'h5959);
      one_edge();
      check("wrap_0000", digits(), 16'h0000);
      check("wrap_state", {14'd0, state}, 16'd1);

      one_edges(58);
      press(0, 1'b0);
      check("pause_0058", digits(), 16'h0058);
      check("pause2_state", {14'd0, state}, 16'd2);
      @(negedge clk) sw = 2'b01;
      repeat (2) @(negedge clk);
      check("adj_state", {14'd0, state}, 16'd3);
      check("adj_blink0", {15'd0, blink}, 16'd0);
      two_edge();
      check("adj_blink1", {15'd0, blink}, 16'd1);
      two_edge();
      two_edge();
      check("adj_sec_wrap", digits(), 16'h0001);
      check("adj_blink3", {15'd0, blink}, 16'd1);
      @(negedge clk) sw = 2'b11;
      two_edge();
      two_edge();
      check("adj_min", digits(), 16'h0201);
      check("adj_blink5", {15'd0, blink}, 16'd1);
      @(negedge clk) sw = 2'b00;
      repeat (2) @(negedge clk);
      check("adj_exit_state", {14'd0, state}, 16'd2);
      check("adj_exit_blink", {15'd0, blink}, 16'd0);
      check("adj_exit_digits", digits(), 16'h0201);

      for (int i = 0; i < 6; i++) begin
         @(negedge clk) btnR = 1'b1;
         repeat (2) @(negedge clk);
         btnR = 1'b0;
         repeat (2) @(negedge clk);
      end
      repeat (DEB + 6) @(negedge clk);
      check("glitch_state", {14'd0, state}, 16'd2);

      press(0, 1'b0);
      check("resume_state", {14'd0, state}, 16'd1);
      press(0, 1'b1);
      check("btnr_tick_digits", digits(), 16'h0202);
      check("btnr_tick_state", {14'd0, state}, 16'd2);
      press(0, 1'b0);
      press(1, 1'b1);
      check("btnl_tick_digits", digits(), 16'h0000);
      check("btnl_tick_state", {14'd0, state}, 16'd0);

      press(0, 1'b0);
      one_edges(754);
      check("run_1234", digits(), 16'h1234);
      @(negedge clk) reset = 1'b0;
      #1;
      check("async_rst_state",  {14'd0, state}, 16'd0);
      check("async_rst_digits", digits(),       16'h0000);
      @(negedge clk) reset = 1'b1;
      one_edges(3);
      check("post_rst_state",  {14'd0, state}, 16'd0);
      check("post_rst_digits", digits(),       16'h0000);
      press(0, 1'b0);
      one_edge();
      check("post_rst_run", digits(), 16'h0001);
      check("post_rst_run_state", {14'd0, state}, 16'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
